// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared state encodings and BCD digit constants for the
//            sequential BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Converter FSM states; encodings are fixed so they can be observed
    // consistently in waveforms and by neighbouring blocks.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    // Width of one BCD digit in bits.
    localparam int unsigned c_DIGIT_W = 4;

    // Largest legal value of a BCD digit.
    localparam logic [3:0] c_DIGIT_MAX = 4'd9;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd2bin_seq_sub3.sv
`default_nettype none
// ============================================================================
// Module   : sub3
// Brief    : Single-digit correction step for reverse double-dabble.
//            A digit that reads 8 or more after the right shift had a
//            weight-10 carry folded in as 8; subtracting 3 restores the
//            proper weight-5 contribution.
// Revision : 1.0 - initial release
// ============================================================================
module sub3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Conditional 4-bit subtract; no borrow leaves the digit.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8) begin
            o_digit = i_digit - 4'd3;
        end
    end

endmodule : sub3
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Sequential BCD-to-binary converter (reverse double-dabble).
//            One bit of the binary result is produced per clock; a
//            start/busy/done handshake keeps one conversion in flight.
//            Inputs containing a non-decimal digit are flagged via err
//            without running the shift loop.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [c_DIGIT_W*DIGITS-1:0]   bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [BIN_W-1:0]              bin_out
);

    localparam int unsigned      c_BCD_W    = c_DIGIT_W * DIGITS;
    localparam int unsigned      c_CNT_W    = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]     r_bin;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_invalid;
    logic                 r_done;
    logic                 r_err;
    logic [BIN_W-1:0]     r_bin_out;

    logic [c_BCD_W-1:0]   w_bcd_shift;
    logic [c_BCD_W-1:0]   w_bcd_corr;
    logic [BIN_W-1:0]     w_bin_shift;
    logic                 w_in_invalid;
    logic                 w_last_step;

    // Right shift of the combined {bcd, bin} register: the BCD LSB moves
    // into the binary MSB.
    assign w_bcd_shift = r_bcd >> 1;
    assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};
    assign w_last_step = (r_cnt == c_CNT_LAST);

    // One corrector per digit; digits are corrected independently.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        sub3 u_sub3 (
            .i_digit (w_bcd_shift[g*c_DIGIT_W +: c_DIGIT_W]),
            .o_digit (w_bcd_corr [g*c_DIGIT_W +: c_DIGIT_W])
        );
    end

    // Flag the incoming operand if any digit lies outside 0..9.
    always_comb begin
        w_in_invalid = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[d*c_DIGIT_W +: c_DIGIT_W] > c_DIGIT_MAX) begin
                w_in_invalid = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; invalid operands skip straight to FIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_in_invalid ? ST_FIN : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift/correct steps and result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_invalid <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bin_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bcd     <= bcd_in;
                        r_bin     <= '0;
                        r_cnt     <= '0;
                        r_invalid <= w_in_invalid;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_bcd_corr;
                    r_bin <= w_bin_shift;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                ST_FIN: begin
                    r_done    <= 1'b1;
                    r_err     <= r_invalid;
                    r_bin_out <= r_invalid ? '0 : r_bin;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin_out;

endmodule : bcd2bin_seq
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin_seq
// Brief    : Directed self-checking bench for bcd2bin_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [11:0]       bcd_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [BIN_W-1:0]  bin_out;

    int n_vec;
    int n_err;

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called on the first negedge after the accepting edge; returns the
    // number of clock edges after acceptance at which done was seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Count done pulses over a window of n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    // Single conversion with a one-cycle start pulse.
    task automatic run(input string tag, input logic [11:0] bcd, input int exp_lat,
                       input logic [9:0] exp_bin, input logic exp_err);
        int lat;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!exp_err) check({tag, "_bcdz"}, 32'(dut.r_bcd), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_bin",  32'(bin_out), 32'd0);
        rst_n = 1'b1;

        // Zero operand and full-scale operand.
        run("zero", 12'h000, 11, 10'd0,   1'b0);
        run("n999", 12'h999, 11, 10'd999, 1'b0);

        // Start held high: second operand accepted right after the first FIN.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h255;
        @(negedge clk);
        bcd_in = 12'h128;
        wait_done(lat);
        check("b2b1_lat", 32'(lat), 32'd11);
        check("b2b1_bin", 32'(bin_out), 32'd255);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 40);
        start = 1'b0;
        check("b2b2_gap", 32'(lat), 32'd12);
        check("b2b2_bin", 32'(bin_out), 32'd128);
        @(negedge clk);

        // Invalid digit, then a valid operand clears err.
        run("inv1A3", 12'h1A3, 1, 10'd0, 1'b1);
        run("n042", 12'h042, 11, 10'd42, 1'b0);

        // Start while busy is ignored.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h500;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h777;
        @(negedge clk);
        start  = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("busy_lat", 32'(lat), 32'd11);
        check("busy_bin", 32'(bin_out), 32'd500);
        count_done(15, cnt);
        check("busy_nodone", 32'(cnt), 32'd0);
        check("busy_bin_hold", 32'(bin_out), 32'd500);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h321;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bin",  32'(bin_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done(15, cnt);
        check("abort_nodone", 32'(cnt), 32'd0);
        run("n321", 12'h321, 11, 10'd321, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd2bin_seq
`default_nettype wire
